// File: rtl/writeback_stage.sv
// Writeback stage: registers the memory-stage result, extends load data and drives the register bank.
// Optional retired-instruction counter enabled by defining WB_RETIRE_COUNT_EN.
module writeback_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        inValid,
  input  logic [4:0]  inRd,
  input  logic        inRegWrite,
  input  logic [1:0]  inResultSel,
  input  logic [31:0] inAluResult,
  input  logic [31:0] inMemData,
  input  logic [1:0]  inAddrLow,
  input  logic [2:0]  inFunct3,
  input  logic [31:0] inPcPlus4,
  input  logic [31:0] inImm,
  output logic [4:0]  rd,
  output logic        regWrite,
  output logic [31:0] writeData,
  output logic        wbValid,
  output logic [31:0] instretCount
);

  logic        valid_r;
  logic [4:0]  rd_r;
  logic        reg_write_r;
  logic [31:0] write_data_r;
  logic        bubble_s;
  logic        wr_en_s;
  logic [31:0] wb_data_s;

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  addr_low,
                                              input logic [2:0]  funct3);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] result_v;
    case (addr_low)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    // Halfword lane ignores addr_low[0]; misaligned halfwords are not trapped here.
    half_v = addr_low[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  result_v = {{24{byte_v[7]}}, byte_v};
      3'b100:  result_v = {24'h000000, byte_v};
      3'b001:  result_v = {{16{half_v[15]}}, half_v};
      3'b101:  result_v = {16'h0000, half_v};
      default: result_v = word;
    endcase
    return result_v;
  endfunction

  // Result selection and write-enable qualification for the incoming entry.
  always_comb begin
    wb_data_s = 32'h0000_0000;
    bubble_s  = flush | stall;
    wr_en_s   = inValid & inRegWrite & (inRd != 5'd0);
    case (inResultSel)
      2'b00:   wb_data_s = inAluResult;
      2'b01:   wb_data_s = load_extend(inMemData, inAddrLow, inFunct3);
      2'b10:   wb_data_s = inPcPlus4;
      2'b11:   wb_data_s = inImm;
      default: wb_data_s = inAluResult;
    endcase
  end

  // Pipeline register; a bubble clears only the control bits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_r      <= 1'b0;
      rd_r         <= 5'd0;
      reg_write_r  <= 1'b0;
      write_data_r <= 32'h0000_0000;
    end else begin
      rd_r         <= inRd;
      write_data_r <= wb_data_s;
      if (bubble_s) begin
        valid_r     <= 1'b0;
        reg_write_r <= 1'b0;
      end else begin
        valid_r     <= inValid;
        reg_write_r <= wr_en_s;
      end
    end
  end

  assign rd        = rd_r;
  assign regWrite  = reg_write_r;
  assign writeData = write_data_r;
  assign wbValid   = valid_r;

`ifdef WB_RETIRE_COUNT_EN
  logic [31:0] instret_r;

  // Counts entries that actually enter WB; wraps naturally at 32 bits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instret_r <= 32'h0000_0000;
    end else if (inValid && !bubble_s) begin
      instret_r <= instret_r + 32'd1;
    end else begin
      instret_r <= instret_r;
    end
  end

  assign instretCount = instret_r;
`else
  assign instretCount = 32'h0000_0000;
`endif

endmodule
